led_display_arbiter: RTL and testbench
======================================

Name: led_display_arbiter

Overview:
- Shares one `led_display_driver` instance between NUM_SOURCES requesters, for example a status readout, a debug register view and an error code.
- Uses a req/grant handshake with round-robin selection.
- Guarantees a minimum dwell time per owner so the display stays readable.
- Inserts a blanking gap on every owner change so no digits from a mixed frame are shown.
- Sits directly in front of the driver's `data`, `digit_enable_mask` and `decimal_point_enable_mask` inputs.

Parameters:
- CLK_RATE_HZ, 390625, frequency of clk; must match the driver instance.
- WIDTH_NIBBLES, 6, display width in digits; must match the driver instance.
- NUM_SOURCES, 4, number of requesters; range 2..16.
- DWELL_MS, 500, minimum time an owner holds the display before preemption.
- BLANK_CYCLES, 64, clk cycles of blanked output between owners; minimum 1.
- DWELL_CYCLES, derived = CLK_RATE_HZ*DWELL_MS/1000; minimum 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- src_req  in  NUM_SOURCES  per-source display request (level).
- src_data  in  NUM_SOURCES*WIDTH_NIBBLES*4  source i occupies slice [i*W*4 +: W*4].
- src_digit_mask  in  NUM_SOURCES*WIDTH_NIBBLES  per-source digit enable.
- src_dp_mask  in  NUM_SOURCES*WIDTH_NIBBLES  per-source decimal-point enable.
- src_grant  out  NUM_SOURCES  one-hot or zero; the current owner.
- data  out  WIDTH_NIBBLES*4  to driver.
- digit_enable_mask  out  WIDTH_NIBBLES  to driver.
- decimal_point_enable_mask  out  WIDTH_NIBBLES  to driver.
- owner_id  out  clog2(NUM_SOURCES)  index of the granted source; 0 when none.
- busy  out  1  high in BLANK or SHOW.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE; src_grant, data, both masks, owner_id and busy all 0.
  - last_owner=NUM_SOURCES-1, so the first search starts at index 0.
- Round-robin pick: the first i with src_req[i]=1, searching last_owner+1 upward and wrapping modulo NUM_SOURCES.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - Outputs are 0.
  - If any src_req is high at an edge, latch pick into cand and go to BLANK, with blank_cnt cleared.
- BLANK:
  - Masks and data are 0; src_grant is 0; busy=1.
  - blank_cnt increments each edge.
  - When blank_cnt reaches BLANK_CYCLES-1, go to SHOW at the next edge. At that edge: owner=cand, last_owner=cand, src_grant[cand]=1, dwell_cnt=0.
  - If src_req[cand] drops during BLANK: re-pick at the next edge and restart blank_cnt if any request remains, else go to IDLE.
- SHOW:
  - Each edge registers the owner's slices into data and both masks. This is one-cycle latency from src_* to the outputs, including the entry edge.
  - dwell_cnt increments and saturates at DWELL_CYCLES.
  - Exit conditions are evaluated each edge, in priority order:
    1. src_req[owner]=0: release. If any other request is pending, go to BLANK with the new pick, else go to IDLE. The grant drops at the same edge.
    2. dwell_cnt==DWELL_CYCLES and another source requests: preempt. The grant drops and the state goes to BLANK with the pick excluding the owner. The preempted source stays eligible if it keeps req high.
    3. Otherwise, stay in SHOW.
- Simultaneous release and dwell expiry are handled as a release.
- A single requester is never preempted.
- Requests arriving during BLANK do not change cand unless cand itself drops.
- Output masks are forced to 0 in every state except SHOW. The driver therefore shows a blank display during IDLE and between owners.
- src_grant is always registered and at most one bit is set; owner_id tracks it.

Decomposition:
- Shared package led_display_pkg:
  - NIBBLE_BITS=4.
  - Segment bit-order constants (a=bit7 .. dp=bit0).
  - Helper function for the CLK_RATE_HZ/ms-to-cycles conversion, shared with the driver's divider.
- One natural sub-module: led_rr_pick, a combinational round-robin priority picker.
  - Inputs: req vector, last index, exclude-enable.
  - Outputs: found flag and index.
  - Reusable by other shared-resource arbiters.

Test Plan (CLK_RATE_HZ=1000, DWELL_MS=10 giving DWELL_CYCLES=10, BLANK_CYCLES=4, NUM_SOURCES=4, WIDTH_NIBBLES=6):
1. Reset mid-SHOW:
   - Stimulus: drive reset_n low asynchronously between edges.
   - Required response: all outputs are 0 immediately. After release, src_req=4'b0110 gives grant 4'b0010.
2. Single requester:
   - Stimulus: src_req=4'b0001 at edge 0, src_data[0]=24'h123456, digit mask 6'h3F.
   - Required response: src_grant=4'b0001 and owner_id=0 from edge 4; data=24'h123456 and digit_enable_mask=6'h3F from edge 4.
   - Hold for 100 cycles: no preemption, no blank.
3. Preemption after dwell:
   - Stimulus: source 0 owns; src_req[2] rises at dwell_cnt=3.
   - Required response: the grant drops exactly when dwell_cnt reaches 10, masks are 0 for 4 cycles, then src_grant=4'b0100.
4. Early release:
   - Stimulus: the owner drops req at dwell_cnt=2 while src_req[3]=1.
   - Required response: BLANK starts at that edge and src_grant=4'b1000 follows after 4 cycles.
   - With no other request instead: IDLE with outputs 0.
5. Rotation fairness:
   - Stimulus: all four requests held high.
   - Required response: grants appear in the order 0,1,2,3,0. Each hold is exactly 10 cycles with a 4-cycle gap, and src_grant is never multi-hot.
6. Candidate withdrawal:
   - Stimulus: src_req[1] drops during BLANK while src_req[3] is high.
   - Required response: blank_cnt restarts and the grant goes to 3 four cycles later.
   - With no other request: IDLE and no grant.

Source files
------------

// File: rtl/led_display_pkg.sv
// rtl/led_display_pkg.sv - shared constants, types and helpers for the LED display blocks
package led_display_pkg;

    localparam int NIBBLE_BITS = 4;

    // Segment bit order of the driver's segment bus (a = MSB, dp = LSB).
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } arb_state_t;

    // Milliseconds to clk cycles, never less than one cycle.
    function automatic int ms_to_cycles(input longint clk_rate_hz, input longint ms);
        longint cycles;
        cycles = (clk_rate_hz * ms) / 1000;
        return (cycles < 1) ? 1 : int'(cycles);
    endfunction

endpackage

// File: rtl/led_display_arbiter_if.sv
// rtl/led_display_arbiter_if.sv - requester and driver-side signals of the display arbiter
//
// master: requesters + display driver side (drives src_*, observes grant/display outputs)
// slave : the arbiter
interface led_display_arbiter_if
    import led_display_pkg::*;
#(
    parameter int NUM_SOURCES   = 4,
    parameter int WIDTH_NIBBLES = 6
);
    localparam int OWNER_W = $clog2(NUM_SOURCES);

    logic [NUM_SOURCES-1:0]                           src_req;
    logic [NUM_SOURCES*WIDTH_NIBBLES*NIBBLE_BITS-1:0] src_data;
    logic [NUM_SOURCES*WIDTH_NIBBLES-1:0]             src_digit_mask;
    logic [NUM_SOURCES*WIDTH_NIBBLES-1:0]             src_dp_mask;
    logic [NUM_SOURCES-1:0]                           src_grant;
    logic [WIDTH_NIBBLES*NIBBLE_BITS-1:0]             data;
    logic [WIDTH_NIBBLES-1:0]                         digit_enable_mask;
    logic [WIDTH_NIBBLES-1:0]                         decimal_point_enable_mask;
    logic [OWNER_W-1:0]                               owner_id;
    logic                                             busy;

    modport master (
        output src_req, src_data, src_digit_mask, src_dp_mask,
        input  src_grant, data, digit_enable_mask, decimal_point_enable_mask, owner_id, busy
    );

    modport slave (
        input  src_req, src_data, src_digit_mask, src_dp_mask,
        output src_grant, data, digit_enable_mask, decimal_point_enable_mask, owner_id, busy
    );

endinterface

// File: rtl/led_rr_pick.sv
// rtl/led_rr_pick.sv - combinational round-robin picker
//
// req     : request vector
// last    : index searched last; the search starts at last+1 and wraps
// exclude : when set, index 'last' itself is not eligible
// found   : some eligible request exists
// idx     : index of the first eligible request (0 when none)
module led_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    input  logic             exclude,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // k == N lands back on 'last'; that is the slot exclude removes.
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(last) + k) % N] && !(exclude && k == N)) begin
                found = 1'b1;
                idx   = IDX_W'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/led_display_arbiter.sv
// rtl/led_display_arbiter.sv - round-robin owner arbitration in front of one LED display driver
//
// clk     : system clock
// reset_n : asynchronous active-low reset
// bus     : slave side of led_display_arbiter_if (src_req/src_data/src masks in,
//           src_grant, data, digit/dp masks, owner_id, busy out; all outputs registered)
module led_display_arbiter
    import led_display_pkg::*;
#(
    parameter int CLK_RATE_HZ   = 390625,
    parameter int WIDTH_NIBBLES = 6,
    parameter int NUM_SOURCES   = 4,
    parameter int DWELL_MS      = 500,
    parameter int BLANK_CYCLES  = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    led_display_arbiter_if.slave bus
);

    localparam int DWELL_CYCLES = ms_to_cycles(CLK_RATE_HZ, DWELL_MS);
    localparam int IDX_W        = $clog2(NUM_SOURCES);
    localparam int SLICE_W      = WIDTH_NIBBLES * NIBBLE_BITS;
    localparam int DWELL_W      = $clog2(DWELL_CYCLES + 1);
    localparam int BLANK_W      = $clog2(BLANK_CYCLES + 1);

    arb_state_t                 state;
    logic [IDX_W-1:0]           cand;
    logic [IDX_W-1:0]           last_owner;   // equals the owner while in SHOW
    logic [BLANK_W-1:0]         blank_cnt;
    logic [DWELL_W-1:0]         dwell_cnt;
    logic [DWELL_W-1:0]         dwell_next;
    logic [NUM_SOURCES-1:0]     grant_q;
    logic [SLICE_W-1:0]         data_q;
    logic [WIDTH_NIBBLES-1:0]   dmask_q;
    logic [WIDTH_NIBBLES-1:0]   dpmask_q;
    logic [IDX_W-1:0]           owner_q;
    logic                       busy_q;

    logic                       pick_found;
    logic [IDX_W-1:0]           pick_idx;
    logic [IDX_W-1:0]           sel;
    logic [SLICE_W-1:0]         sel_data;
    logic [WIDTH_NIBBLES-1:0]   sel_dmask;
    logic [WIDTH_NIBBLES-1:0]   sel_dpmask;

    // While showing, the owner may not re-pick itself: a preemption must hand
    // over to someone else, and on release its request is already low.
    led_rr_pick #(
        .N     (NUM_SOURCES),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.src_req),
        .last    (last_owner),
        .exclude (state == ST_SHOW),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // On the SHOW entry edge the slice comes from cand, afterwards from the owner.
    assign sel        = (state == ST_SHOW) ? last_owner : cand;
    assign sel_data   = bus.src_data[sel*SLICE_W +: SLICE_W];
    assign sel_dmask  = bus.src_digit_mask[sel*WIDTH_NIBBLES +: WIDTH_NIBBLES];
    assign sel_dpmask = bus.src_dp_mask[sel*WIDTH_NIBBLES +: WIDTH_NIBBLES];

    // Dwell expiry is judged on the value the counter reaches at this edge, so
    // an owner holds the grant for exactly DWELL_CYCLES cycles before preemption.
    assign dwell_next = (dwell_cnt == DWELL_W'(DWELL_CYCLES)) ? dwell_cnt
                                                              : dwell_cnt + DWELL_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cand       <= '0;
            last_owner <= IDX_W'(NUM_SOURCES - 1);
            blank_cnt  <= '0;
            dwell_cnt  <= '0;
            grant_q    <= '0;
            data_q     <= '0;
            dmask_q    <= '0;
            dpmask_q   <= '0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state     <= ST_BLANK;
                        cand      <= pick_idx;
                        blank_cnt <= '0;
                        busy_q    <= 1'b1;
                    end
                end

                ST_BLANK: begin
                    if (!bus.src_req[cand]) begin
                        if (pick_found) begin
                            cand      <= pick_idx;
                            blank_cnt <= '0;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else if (blank_cnt == BLANK_W'(BLANK_CYCLES - 1)) begin
                        state      <= ST_SHOW;
                        last_owner <= cand;
                        owner_q    <= cand;
                        grant_q    <= NUM_SOURCES'(1) << cand;
                        dwell_cnt  <= '0;
                        data_q     <= sel_data;
                        dmask_q    <= sel_dmask;
                        dpmask_q   <= sel_dpmask;
                    end else begin
                        blank_cnt <= blank_cnt + BLANK_W'(1);
                    end
                end

                ST_SHOW: begin
                    if (!bus.src_req[last_owner] ||
                        (dwell_next == DWELL_W'(DWELL_CYCLES) && pick_found)) begin
                        // Release or preemption: both blank the display and drop the grant now.
                        grant_q  <= '0;
                        owner_q  <= '0;
                        data_q   <= '0;
                        dmask_q  <= '0;
                        dpmask_q <= '0;
                        if (pick_found) begin
                            state     <= ST_BLANK;
                            cand      <= pick_idx;
                            blank_cnt <= '0;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        dwell_cnt <= dwell_next;
                        data_q    <= sel_data;
                        dmask_q   <= sel_dmask;
                        dpmask_q  <= sel_dpmask;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    grant_q  <= '0;
                    owner_q  <= '0;
                    data_q   <= '0;
                    dmask_q  <= '0;
                    dpmask_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.src_grant                 = grant_q;
    assign bus.data                      = data_q;
    assign bus.digit_enable_mask         = dmask_q;
    assign bus.decimal_point_enable_mask = dpmask_q;
    assign bus.owner_id                  = owner_q;
    assign bus.busy                      = busy_q;

endmodule

// File: tb/tb_led_display_arbiter.sv
// tb/tb_led_display_arbiter.sv - self-checking bench for led_display_arbiter
module tb_led_display_arbiter;

    localparam int NS    = 4;
    localparam int WN    = 6;
    localparam int SW    = WN * 4;
    localparam int DWELL = 10;
    localparam int BLANK = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    led_display_arbiter_if #(.NUM_SOURCES(NS), .WIDTH_NIBBLES(WN)) bus ();

    led_display_arbiter #(
        .CLK_RATE_HZ   (1000),
        .WIDTH_NIBBLES (WN),
        .NUM_SOURCES   (NS),
        .DWELL_MS      (10),
        .BLANK_CYCLES  (BLANK)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who is shown, who waits in the gap, how long each has lasted.
    int          m_owner;   // -1: nobody shown
    int          m_cand;    // -1: nobody waiting in a gap
    int          m_gap;     // gap cycles already spent
    int          m_held;    // edges since the owner was granted
    int          m_last;
    logic [SW-1:0] m_data;
    logic [WN-1:0] m_dm;
    logic [WN-1:0] m_dp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int rr_after(input int after, input bit skip_after);
        for (int k = 1; k <= NS; k++) begin
            if (bus.src_req[(after + k) % NS] && !(skip_after && k == NS))
                return (after + k) % NS;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_cand = -1; m_gap = 0; m_held = 0; m_last = NS - 1;
        m_data = '0; m_dm = '0; m_dp = '0;
    endtask

    task automatic model_gap(input int p);
        m_owner = -1; m_cand = p; m_gap = 0;
        m_data = '0; m_dm = '0; m_dp = '0;
    endtask

    task automatic model_latch(input int s);
        m_data = bus.src_data[s*SW +: SW];
        m_dm   = bus.src_digit_mask[s*WN +: WN];
        m_dp   = bus.src_dp_mask[s*WN +: WN];
    endtask

    task automatic model_step();
        if (m_owner >= 0) begin
            if (!bus.src_req[m_owner]) model_gap(rr_after(m_last, 1'b1));
            else if (m_held + 1 >= DWELL && rr_after(m_last, 1'b1) >= 0) model_gap(rr_after(m_last, 1'b1));
            else begin m_held++; model_latch(m_owner); end
        end else if (m_cand >= 0) begin
            if (!bus.src_req[m_cand]) model_gap(rr_after(m_last, 1'b0));
            else if (m_gap == BLANK - 1) begin
                m_owner = m_cand; m_last = m_cand; m_cand = -1; m_held = 0;
                model_latch(m_owner);
            end else m_gap++;
        end else begin
            model_gap(rr_after(m_last, 1'b0));
        end
    endtask

    task automatic check_model();
        logic [NS-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        check("m_grant", bus.src_grant, g);
        check("m_owner_id", bus.owner_id, (m_owner >= 0) ? m_owner : 0);
        check("m_busy", bus.busy, (m_owner >= 0 || m_cand >= 0) ? 1 : 0);
        check("m_data", bus.data, m_data);
        check("m_dmask", bus.digit_enable_mask, m_dm);
        check("m_dpmask", bus.decimal_point_enable_mask, m_dp);
        check("grant_onehot0", ($countones(bus.src_grant) <= 1) ? 1 : 0, 1);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic set_src(input int i, input logic [SW-1:0] d, input logic [WN-1:0] dm, input logic [WN-1:0] dp);
        bus.src_data[i*SW +: SW]       = d;
        bus.src_digit_mask[i*WN +: WN] = dm;
        bus.src_dp_mask[i*WN +: WN]    = dp;
    endtask

    int   seq[$];
    int   holds[$];
    int   gaps[$];
    int   run;
    int   hold_ok;
    logic [NS-1:0] prev;

    initial begin
        bus.src_req = '0; bus.src_data = '0; bus.src_digit_mask = '0; bus.src_dp_mask = '0;
        for (int i = 0; i < NS; i++) set_src(i, SW'($urandom), WN'($urandom), WN'($urandom));
        set_src(0, 24'h123456, 6'h3F, 6'h05);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        check("reset_busy", bus.busy, 0);
        reset_n = 1'b1;

        // Single requester: grant and data from edge 4, never preempted.
        bus.src_req = 4'b0001;
        repeat (4) step();
        check("single_pre_grant", bus.src_grant, 4'b0000);
        step();
        check("single_grant", bus.src_grant, 4'b0001);
        check("single_owner", bus.owner_id, 0);
        check("single_data", bus.data, 24'h123456);
        check("single_dmask", bus.digit_enable_mask, 6'h3F);
        hold_ok = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (bus.src_grant == 4'b0001 && bus.digit_enable_mask == 6'h3F) hold_ok++;
        end
        check("single_hold_cycles", hold_ok, 100);

        // Release with nobody else waiting goes idle.
        bus.src_req = 4'b0000;
        step();
        check("release_idle_busy", bus.busy, 0);
        check("release_idle_grant", bus.src_grant, 0);

        // Preemption after dwell: req[2] rises at dwell 3, grant drops when dwell reaches 10.
        bus.src_req = 4'b0001;
        repeat (5) step();
        check("preempt_owner0", bus.src_grant, 4'b0001);
        repeat (3) step();
        bus.src_req = 4'b0101;
        repeat (6) step();
        check("preempt_not_yet", bus.src_grant, 4'b0001);
        step();
        check("preempt_drop", bus.src_grant, 4'b0000);
        check("preempt_dmask0", bus.digit_enable_mask, 0);
        repeat (3) step();
        check("preempt_gap_grant", bus.src_grant, 4'b0000);
        step();
        check("preempt_new_owner", bus.src_grant, 4'b0100);

        // Early release at dwell 2 with req[3] pending.
        bus.src_req = 4'b1100;
        repeat (2) step();
        bus.src_req = 4'b1000;
        step();
        check("early_rel_grant", bus.src_grant, 4'b0000);
        check("early_rel_busy", bus.busy, 1);
        repeat (3) step();
        check("early_rel_gap", bus.src_grant, 4'b0000);
        step();
        check("early_rel_owner3", bus.src_grant, 4'b1000);
        bus.src_req = 4'b0000;
        step();
        check("early_rel_idle", bus.busy, 0);

        // Rotation with all requests high.
        bus.src_req = 4'b1111;
        prev = '0; run = 0;
        for (int c = 0; c < 100 && seq.size() < 5; c++) begin
            step();
            if ((bus.src_grant != 0) != (prev != 0)) begin
                if (bus.src_grant != 0) begin gaps.push_back(run); seq.push_back(int'(bus.owner_id)); end
                else holds.push_back(run);
                run = 1;
            end else run++;
            prev = bus.src_grant;
        end
        check("rot_grant_count", seq.size(), 5);
        foreach (seq[k]) check($sformatf("rot_order_%0d", k), seq[k], k % NS);
        foreach (holds[k]) check($sformatf("rot_hold_%0d", k), holds[k], DWELL);
        foreach (gaps[k]) check($sformatf("rot_gap_%0d", k), gaps[k], BLANK);

        // Candidate withdrawal during BLANK.
        bus.src_req = 4'b0000;
        step();
        bus.src_req = 4'b1010;
        repeat (2) step();
        bus.src_req = 4'b1000;
        step();
        check("withdraw_busy", bus.busy, 1);
        repeat (3) step();
        check("withdraw_gap", bus.src_grant, 4'b0000);
        step();
        check("withdraw_owner3", bus.src_grant, 4'b1000);
        bus.src_req = 4'b0000;
        step();
        bus.src_req = 4'b0010;
        repeat (2) step();
        bus.src_req = 4'b0000;
        step();
        check("withdraw_idle_busy", bus.busy, 0);
        check("withdraw_idle_grant", bus.src_grant, 0);

        // Asynchronous reset in the middle of SHOW.
        set_src(1, 24'hABCDEF, 6'h2A, 6'h11);
        bus.src_req = 4'b0010;
        repeat (5) step();
        check("rst_pre_grant", bus.src_grant, 4'b0010);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_grant", bus.src_grant, 0);
        check("rst_data", bus.data, 0);
        check("rst_dmask", bus.digit_enable_mask, 0);
        check("rst_dpmask", bus.decimal_point_enable_mask, 0);
        check("rst_owner", bus.owner_id, 0);
        check("rst_busy", bus.busy, 0);
        model_reset();
        @(posedge clk);
        #1;
        check_model();
        reset_n = 1'b1;
        bus.src_req = 4'b0110;
        repeat (5) step();
        check("rst_after_grant", bus.src_grant, 4'b0010);

        // Randomised traffic against the model.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(7) == 0) bus.src_req[$urandom_range(NS-1)] ^= 1'b1;
            set_src($urandom_range(NS-1), SW'($urandom), WN'($urandom), WN'($urandom));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
